// File: rtl/button_conditioner_pkg.sv
// Shared constants and types for the push-button conditioning path.
// Bit indices match the game_top button_i layout.
package button_conditioner_pkg;

    localparam int BTN_NUM   = 5;
    localparam int BTN_MID   = 4;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 0;

    localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 15_000_000;
    localparam logic [BTN_NUM-1:0] DEF_REPEAT_MASK = 5'b01111;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce, press one-shot and optional auto-repeat.
// Every output is a flop; the raw pin only reaches logic through the synchroniser.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TMR_W = max_int($clog2(REPEAT_DELAY), $clog2(REPEAT_PERIOD));
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic             sync_p0, sync_p1;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt;
    rpt_state_e       state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             pulse_nxt;

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        if (sync_p1 != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = sync_p1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Pulse/repeat decisions use the level being registered this edge, so a
    // release never coincides with a repeat pulse
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        pulse_nxt = 1'b0;
        if (!level_nxt) begin
            state_nxt = RPT_IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (!level) begin
                        pulse_nxt = 1'b1;
                        tmr_nxt   = '0;
                        if (REPEAT_EN) state_nxt = RPT_HOLD;
                    end
                end
                RPT_HOLD: begin
                    if (tmr == DELAY_LAST) begin
                        pulse_nxt = 1'b1;
                        tmr_nxt   = '0;
                        state_nxt = RPT_REPEAT;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (tmr == PERIOD_LAST) begin
                        pulse_nxt = 1'b1;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state_nxt = RPT_IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            state   <= RPT_IDLE;
            tmr     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            cnt     <= cnt_nxt;
            level   <= level_nxt;
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            pulse   <= pulse_nxt;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the five board push-buttons into single-cycle pulses for game_top.button_i.
// Pure wiring: one button_channel per pin, repeat enabled per REPEAT_MASK bit.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [BTN_NUM-1:0] REPEAT_MASK = DEF_REPEAT_MASK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BTN_NUM-1:0] button_raw_i,
    output logic [BTN_NUM-1:0] button_o,
    output logic [BTN_NUM-1:0] button_level_o
);

    for (genvar i = 0; i < BTN_NUM; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (button_raw_i[i]),
            .pulse (button_o[i]),
            .level (button_level_o[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a per-cycle reference model of
// the press/repeat timing rules and hand-computed pulse-time expectations.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [4:0] MASK = 5'b01111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] button_raw;
    logic [4:0] button_o;
    logic [4:0] button_level;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pq [5][$];

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .REPEAT_MASK     (MASK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .button_raw_i   (button_raw),
        .button_o       (button_o),
        .button_level_o (button_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 5; i++) pq[i].delete();
    endtask

    // Reference model: inputs present at a negedge are the ones the next posedge samples
    initial begin : model
        bit   s1 [5];
        bit   s2 [5];
        bit   lvl [5];
        int   run [5];
        int   e0 [5];
        logic [4:0] exp_o, exp_l;
        int   n;
        bit   used, prev, rise, rep;
        for (int i = 0; i < 5; i++) begin
            s1[i] = 0; s2[i] = 0; lvl[i] = 0; run[i] = 0; e0[i] = -1;
        end
        exp_o = '0;
        exp_l = '0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                checks++;
                if (button_o !== exp_o) begin
                    errors++;
                    $display("FAIL model_button_o: got %b expected %b (cycle %0d)", button_o, exp_o, cyc);
                end
                checks++;
                if (button_level !== exp_l) begin
                    errors++;
                    $display("FAIL model_level: got %b expected %b (cycle %0d)", button_level, exp_l, cyc);
                end
                for (int i = 0; i < 5; i++) if (button_o[i] === 1'b1) pq[i].push_back(cyc);
            end
            n = cyc + 1;
            for (int i = 0; i < 5; i++) begin
                if (!rst_n) begin
                    s1[i] = 0; s2[i] = 0; lvl[i] = 0; run[i] = 0; e0[i] = -1;
                    exp_o[i] = 1'b0;
                    exp_l[i] = 1'b0;
                end else begin
                    used  = s2[i];
                    s2[i] = s1[i];
                    s1[i] = button_raw[i];
                    prev  = lvl[i];
                    if (used != lvl[i]) run[i]++;
                    else run[i] = 0;
                    if (run[i] == D) begin
                        lvl[i] = used;
                        run[i] = 0;
                    end
                    rise = lvl[i] && !prev;
                    if (rise) e0[i] = n;
                    if (!lvl[i]) e0[i] = -1;
                    rep = MASK[i] && lvl[i] && !rise && (e0[i] >= 0) && ((n - e0[i]) >= RD)
                          && (((n - e0[i] - RD) % RP) == 0);
                    exp_o[i] = rise || rep;
                    exp_l[i] = lvl[i];
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k, p, rr;
        rst_n      = 1'b0;
        button_raw = '0;
        tick(3);
        chk("reset_button_o", int'(button_o), 0);
        chk("reset_level", int'(button_level), 0);
        rst_n = 1'b1;
        tick(3);

        // 1: bouncing middle button, then a clean hold
        clear_log();
        for (int i = 0; i < 10; i++) begin
            button_raw[4] = (i % 2 == 0);
            tick(2);
        end
        button_raw[4] = 1'b1;
        k = cyc + 1;
        tick(20);
        chk("bounce_pulse_count", pq[4].size(), 1);
        chk("bounce_pulse_time", (pq[4].size() > 0) ? pq[4][0] : -1, k + 5);
        chk("bounce_level", int'(button_level[4]), 1);
        button_raw[4] = 1'b0;
        tick(8);
        chk("bounce_release_level", int'(button_level[4]), 0);

        // 2: left held -> press then repeats, released so level falls after P+20
        clear_log();
        button_raw[3] = 1'b1;
        k = cyc + 1;
        p = k + 5;
        wait_until(p + 14);
        button_raw[3] = 1'b0;
        tick(15);
        chk("repeat_count", pq[3].size(), 5);
        if (pq[3].size() == 5) begin
            chk("repeat_t0", pq[3][0], p);
            chk("repeat_t1", pq[3][1], p + 10);
            chk("repeat_t2", pq[3][2], p + 13);
            chk("repeat_t3", pq[3][3], p + 16);
            chk("repeat_t4", pq[3][4], p + 19);
        end

        // 3: middle held 40 cycles never repeats, other bits stay quiet
        clear_log();
        button_raw[4] = 1'b1;
        tick(40);
        chk("mid_hold_count", pq[4].size(), 1);
        chk("mid_hold_others", pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size(), 0);
        button_raw[4] = 1'b0;
        tick(8);

        // 4: short release glitch on up does not disturb repeat phase
        clear_log();
        button_raw[1] = 1'b1;
        k = cyc + 1;
        p = k + 5;
        wait_until(p + 3);
        button_raw[1] = 1'b0;
        tick(3);
        button_raw[1] = 1'b1;
        wait_until(p + 23);
        chk("glitch_count", pq[1].size(), 6);
        if (pq[1].size() == 6) begin
            chk("glitch_t1", pq[1][1], p + 10);
            chk("glitch_t5", pq[1][5], p + 22);
        end
        chk("glitch_level", int'(button_level[1]), 1);
        button_raw[1] = 1'b0;
        tick(8);

        // 5: reset while right is repeating
        button_raw[2] = 1'b1;
        tick(20);
        rst_n = 1'b0;
        rr = cyc + 1;
        tick(1);
        chk("midreset_button_o", int'(button_o), 0);
        chk("midreset_level", int'(button_level), 0);
        rst_n = 1'b1;
        clear_log();
        wait_until(rr + 17);
        chk("midreset_count", pq[2].size(), 2);
        chk("midreset_press", (pq[2].size() > 0) ? pq[2][0] : -1, rr + 6);
        chk("midreset_repeat", (pq[2].size() > 1) ? pq[2][1] : -1, rr + 16);
        button_raw[2] = 1'b0;
        tick(8);

        // 6: two channels pressed on the same edge
        clear_log();
        button_raw = 5'b00101;
        k = cyc + 1;
        wait_until(k + 5);
        chk("simul_button_o", int'(button_o), 5);
        chk("simul_level", int'(button_level), 5);
        tick(1);
        chk("simul_after", int'(button_o), 0);
        button_raw = '0;
        tick(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
